// File: rtl/atomic_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ SM atomic requests into one atomic unit,
// with an in-order tag FIFO routing each completion back to its requester.
module atomic_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 40,
    parameter int DATA_W    = 64,
    parameter int OP_W      = 3,
    parameter int TAG_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REQ-1:0]             sm_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]      sm_req_addr,
    input  logic [NUM_REQ*OP_W-1:0]        sm_req_op,
    input  logic [NUM_REQ*DATA_W-1:0]      sm_req_src,
    output logic [NUM_REQ-1:0]             sm_req_ready,
    output logic                           au_req_valid,
    output logic [ADDR_W-1:0]              au_req_addr,
    output logic [OP_W-1:0]                au_req_op,
    output logic [DATA_W-1:0]              au_req_src,
    input  logic                           au_req_ready,
    input  logic                           au_resp_valid,
    input  logic [DATA_W-1:0]              au_resp_data,
    output logic [NUM_REQ-1:0]             sm_resp_valid,
    output logic [DATA_W-1:0]              sm_resp_data,
    output logic [$clog2(TAG_DEPTH):0]     inflight,
    output logic                           err_orphan
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam logic [IDX_W:0]   NUM_C   = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TAG_DEPTH);

    logic                 or_valid;
    logic [ADDR_W-1:0]    or_addr;
    logic [OP_W-1:0]      or_op;
    logic [DATA_W-1:0]    or_src;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     inflight_q;
    logic [IDX_W-1:0]     tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    logic                 can_grant;
    logic                 grant_any;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IDX_W:0]       sum;
    logic [ADDR_W-1:0]    sel_addr;
    logic [OP_W-1:0]      sel_op;
    logic [DATA_W-1:0]    sel_src;
    logic                 pop;
    logic                 orphan;

    // Full check uses the registered count only: a same-cycle pop never frees a slot early.
    assign can_grant = (!or_valid || au_req_ready) && (inflight_q < DEPTH_C);
    assign pop       = au_resp_valid && (inflight_q != '0);
    assign orphan    = au_resp_valid && (inflight_q == '0);

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= NUM_C) sum = sum - NUM_C;
            if (can_grant && !grant_any && sm_req_valid[sum[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[IDX_W-1:0];
            end
        end
        if (grant_any) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_addr = '0;
        sel_op   = '0;
        sel_src  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr = sm_req_addr[i*ADDR_W +: ADDR_W];
                sel_op   = sm_req_op[i*OP_W +: OP_W];
                sel_src  = sm_req_src[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant is combinational, so it must be gated by reset directly.
    assign sm_req_ready = grant_oh & {NUM_REQ{rstn}};
    assign au_req_valid = or_valid;
    assign au_req_addr  = or_addr;
    assign au_req_op    = or_op;
    assign au_req_src   = or_src;
    assign inflight     = inflight_q;

    always_ff @(posedge clk) begin
        if (grant_any) tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            or_valid      <= 1'b0;
            or_addr       <= '0;
            or_op         <= '0;
            or_src        <= '0;
            rr_ptr        <= '0;
            inflight_q    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            sm_resp_valid <= '0;
            sm_resp_data  <= '0;
            err_orphan    <= 1'b0;
        end else begin
            if (grant_any) begin
                or_valid <= 1'b1;
                or_addr  <= sel_addr;
                or_op    <= sel_op;
                or_src   <= sel_src;
                rr_ptr   <= (grant_idx == LAST_C) ? '0 : grant_idx + IDX_W'(1);
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end else if (or_valid && au_req_ready) begin
                or_valid <= 1'b0;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                sm_resp_data <= au_resp_data;
            end
            sm_resp_valid <= pop ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << tag_mem[rd_ptr]) : '0;
            case ({grant_any, pop})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
            if (orphan) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_atomic_arbiter.sv
// Directed bench for atomic_arbiter: scoreboard queues for atomic-unit requests and
// SM completions, checked by a negedge monitor, plus directed grant/state checks.
module tb_atomic_arbiter;
    localparam int N  = 4;
    localparam int AW = 40;
    localparam int DW = 64;
    localparam int OW = 3;
    localparam int PW = AW + OW + DW;
    localparam int RW = N + DW;

    logic              clk;
    logic              rstn;
    logic [N-1:0]      sm_req_valid;
    logic [N*AW-1:0]   sm_req_addr;
    logic [N*OW-1:0]   sm_req_op;
    logic [N*DW-1:0]   sm_req_src;
    logic [N-1:0]      sm_req_ready;
    logic              au_req_valid;
    logic [AW-1:0]     au_req_addr;
    logic [OW-1:0]     au_req_op;
    logic [DW-1:0]     au_req_src;
    logic              au_req_ready;
    logic              au_resp_valid;
    logic [DW-1:0]     au_resp_data;
    logic [N-1:0]      sm_resp_valid;
    logic [DW-1:0]     sm_resp_data;
    logic [2:0]        inflight;
    logic              err_orphan;

    logic [AW-1:0] addr_tab [N];
    logic [OW-1:0] op_tab   [N];
    logic [DW-1:0] src_tab  [N];
    logic [PW-1:0] au_exp_q [$];
    logic [RW-1:0] resp_exp_q [$];
    int checks;
    int errors;

    atomic_arbiter dut (
        .clk(clk), .rstn(rstn),
        .sm_req_valid(sm_req_valid), .sm_req_addr(sm_req_addr),
        .sm_req_op(sm_req_op), .sm_req_src(sm_req_src), .sm_req_ready(sm_req_ready),
        .au_req_valid(au_req_valid), .au_req_addr(au_req_addr), .au_req_op(au_req_op),
        .au_req_src(au_req_src), .au_req_ready(au_req_ready),
        .au_resp_valid(au_resp_valid), .au_resp_data(au_resp_data),
        .sm_resp_valid(sm_resp_valid), .sm_resp_data(sm_resp_data),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_au(input int i);
        au_exp_q.push_back({addr_tab[i], op_tab[i], src_tab[i]});
    endtask

    task automatic push_resp(input int t, input logic [DW-1:0] d);
        logic [N-1:0] oh;
        oh = 4'b0001 << t;
        resp_exp_q.push_back({oh, d});
    endtask

    task automatic grant_check(input string name, input logic [N-1:0] exp);
        #1;
        check(name, sm_req_ready, exp);
    endtask

    // monitor: pops the scoreboards whenever the DUT presents a transfer
    initial begin
        logic [PW-1:0] pe;
        logic [RW-1:0] re;
        forever begin
            @(negedge clk);
            if (rstn && au_req_valid && au_req_ready) begin
                if (au_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL au_req_unexpected: got addr 0x%0h with empty queue", au_req_addr);
                end else begin
                    pe = au_exp_q.pop_front();
                    check("au_req_payload", {au_req_addr, au_req_op, au_req_src}, pe);
                end
            end
            if (rstn && sm_resp_valid != '0) begin
                if (resp_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sm_resp_unexpected: got valid 0x%0h with empty queue", sm_resp_valid);
                end else begin
                    re = resp_exp_q.pop_front();
                    check("sm_resp", {sm_resp_valid, sm_resp_data}, re);
                end
            end
        end
    end

    // driver / directed sequence
    initial begin
        int ord [4];
        int rem [4];
        checks = 0;
        errors = 0;
        addr_tab = '{40'h00_1234_0000, 40'h00_5678_1000, 40'hAB_CDEF_2000, 40'hFF_0000_3000};
        op_tab   = '{3'd0, 3'd1, 3'd0, 3'd1};
        src_tab  = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                     64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
        for (int i = 0; i < N; i++) begin
            sm_req_addr[i*AW +: AW] = addr_tab[i];
            sm_req_op[i*OW +: OW]   = op_tab[i];
            sm_req_src[i*DW +: DW]  = src_tab[i];
        end
        rstn = 1'b0; sm_req_valid = '0; au_req_ready = 1'b0;
        au_resp_valid = 1'b0; au_resp_data = '0;
        repeat (3) tick();

        // reset state, grant gated while in reset
        sm_req_valid = 4'b1111;
        grant_check("reset_ready_gated", 4'b0000);
        check("reset_au_req_valid", au_req_valid, 1'b0);
        check("reset_inflight", inflight, 3'd0);
        check("reset_err_orphan", err_orphan, 1'b0);
        check("reset_sm_resp", {sm_resp_valid, sm_resp_data}, '0);
        sm_req_valid = '0;
        rstn = 1'b1;
        tick();

        // scenario 1: all valid, AU always ready, responses keep one in flight
        for (int k = 0; k < 5; k++) begin
            sm_req_valid  = 4'b1111;
            au_req_ready  = 1'b1;
            au_resp_valid = (k > 0);
            au_resp_data  = 64'hA0 + 64'(k);
            if (k > 0) push_resp((k - 1) % 4, 64'hA0 + 64'(k));
            grant_check($sformatf("rr_grant_%0d", k), 4'b0001 << (k % 4));
            check($sformatf("au_valid_lat_%0d", k), au_req_valid, (k > 0));
            check($sformatf("inflight_s1_%0d", k), inflight, (k > 0) ? 3'd1 : 3'd0);
            push_au(k % 4);
            tick();
        end
        sm_req_valid = '0; au_resp_valid = 1'b1; au_resp_data = 64'hA5;
        push_resp(0, 64'hA5);
        grant_check("s1_no_grant", 4'b0000);
        tick();
        au_resp_valid = 1'b0;
        tick(); tick();
        check("s1_inflight_done", inflight, 3'd0);

        // scenario 2: valid=0101 with rr_ptr=1 -> 2 then 0
        sm_req_valid = 4'b0101;
        grant_check("s2_grant_2", 4'b0100);
        push_au(2);
        tick();
        grant_check("s2_grant_0", 4'b0001);
        push_au(0);
        tick();
        sm_req_valid = '0;
        au_resp_valid = 1'b1; au_resp_data = 64'h33; push_resp(2, 64'h33);
        tick();
        au_resp_data = 64'h44; push_resp(0, 64'h44);
        tick();
        au_resp_valid = 1'b0;
        tick();

        // scenario 3: fill all tags, blocked, resume one cycle after a response
        ord = '{1, 2, 3, 0};
        for (int c = 0; c < 4; c++) begin
            sm_req_valid = 4'b1111;
            grant_check($sformatf("s3_grant_%0d", c), 4'b0001 << ord[c]);
            check($sformatf("s3_inflight_%0d", c), inflight, 3'(c));
            push_au(ord[c]);
            tick();
        end
        grant_check("s3_full_block", 4'b0000);
        check("s3_inflight_full", inflight, 3'd4);
        au_resp_valid = 1'b1; au_resp_data = 64'h55; push_resp(1, 64'h55);
        grant_check("s3_pop_no_relax", 4'b0000);
        tick();
        au_resp_valid = 1'b0;
        grant_check("s3_resume", 4'b0010);
        check("s3_inflight_after_pop", inflight, 3'd3);
        push_au(1);
        tick();
        sm_req_valid = '0;
        #1;
        check("s3_inflight_refull", inflight, 3'd4);
        rem = '{2, 3, 0, 1};
        for (int j = 0; j < 4; j++) begin
            au_resp_valid = 1'b1; au_resp_data = 64'h56 + 64'(j);
            push_resp(rem[j], 64'h56 + 64'(j));
            tick();
        end
        au_resp_valid = 1'b0;
        #1;
        check("s3_inflight_drained", inflight, 3'd0);

        // scenario 3b: AU stalls, OR holds stable and blocks further grants
        au_req_ready = 1'b0;
        sm_req_valid = 4'b1111;
        grant_check("s3b_grant_2", 4'b0100);
        push_au(2);
        tick();
        for (int s = 0; s < 2; s++) begin
            grant_check($sformatf("s3b_stall_nogrant_%0d", s), 4'b0000);
            check($sformatf("s3b_stable_%0d", s), {au_req_valid, au_req_addr, au_req_op, au_req_src},
                  {1'b1, addr_tab[2], op_tab[2], src_tab[2]});
            tick();
        end
        sm_req_valid = '0; au_req_ready = 1'b1;
        tick();
        au_resp_valid = 1'b1; au_resp_data = 64'h66; push_resp(2, 64'h66);
        tick();
        au_resp_valid = 1'b0;
        tick();

        // scenario 4: grants 3 then 1, responses 0x11 then 0x22 as single-cycle pulses
        sm_req_valid = 4'b1000;
        grant_check("s4_grant_3", 4'b1000);
        push_au(3);
        tick();
        sm_req_valid = 4'b0010;
        grant_check("s4_grant_1", 4'b0010);
        push_au(1);
        tick();
        sm_req_valid = '0;
        tick();
        au_resp_valid = 1'b1; au_resp_data = 64'h11; push_resp(3, 64'h11);
        tick();
        au_resp_valid = 1'b0;
        #1;
        check("s4_pulse_3", {sm_resp_valid, sm_resp_data}, {4'b1000, 64'h11});
        tick();
        check("s4_pulse_3_end", sm_resp_valid, 4'b0000);
        au_resp_valid = 1'b1; au_resp_data = 64'h22; push_resp(1, 64'h22);
        tick();
        au_resp_valid = 1'b0;
        #1;
        check("s4_pulse_1", {sm_resp_valid, sm_resp_data}, {4'b0010, 64'h22});
        tick();
        check("s4_data_hold", {sm_resp_valid, sm_resp_data}, {4'b0000, 64'h22});

        // scenario 5: orphan response
        check("s5_orphan_clear", err_orphan, 1'b0);
        au_resp_valid = 1'b1; au_resp_data = 64'h77;
        tick();
        au_resp_valid = 1'b0;
        #1;
        check("s5_orphan_set", {err_orphan, inflight, sm_resp_valid}, {1'b1, 3'd0, 4'b0000});
        repeat (3) tick();
        check("s5_orphan_sticky", err_orphan, 1'b1);

        // scenario 6: reset with two in flight
        sm_req_valid = 4'b0001;
        grant_check("s6_grant_0", 4'b0001);
        push_au(0);
        tick();
        sm_req_valid = 4'b0010;
        grant_check("s6_grant_1", 4'b0010);
        push_au(1);
        tick();
        sm_req_valid = 4'b1111;
        #1;
        check("s6_inflight_2", inflight, 3'd2);
        rstn = 1'b0;
        #1;
        check("s6_async_ready", sm_req_ready, 4'b0000);
        check("s6_async_au", {au_req_valid, au_req_addr, au_req_op, au_req_src}, '0);
        check("s6_async_state", {inflight, err_orphan, sm_resp_valid, sm_resp_data}, '0);
        au_exp_q.delete();
        sm_req_valid = '0;
        tick();
        rstn = 1'b1;
        tick();
        check("s6_inflight_post", inflight, 3'd0);
        au_resp_valid = 1'b1; au_resp_data = 64'h88;
        tick();
        au_resp_valid = 1'b0;
        #1;
        check("s6_post_reset_orphan", {err_orphan, sm_resp_valid}, {1'b1, 4'b0000});
        tick(); tick();

        // final report
        check("au_queue_drained", 128'(au_exp_q.size()), 128'd0);
        check("resp_queue_drained", 128'(resp_exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
